// File: rtl/spi_ram_pkg.sv
// Shared command encoding and pointer-arming state for the SPI-attached RAM controller.
package spi_ram_pkg;

   typedef logic [1:0] cmd_t;

   localparam cmd_t CMD_WR_ADDR = 2'b00;
   localparam cmd_t CMD_WR_DATA = 2'b01;
   localparam cmd_t CMD_RD_ADDR = 2'b10;
   localparam cmd_t CMD_RD_DATA = 2'b11;

   typedef enum logic {
      UNARMED = 1'b0,
      ARMED   = 1'b1
   } arm_state_e;

endpackage

// File: rtl/spi_ram_ctrl_ram_array.sv
// MEM_DEPTH x WORD_SIZE storage: synchronous write port, synchronous registered read port.
module ram_array #(
   parameter int WORD_SIZE = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AW        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [WORD_SIZE-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [AW-1:0]        raddr_i,
   output logic [WORD_SIZE-1:0] rdata_o
);

   logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
   logic [WORD_SIZE-1:0] rdata_q;

   // Storage itself is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI RAM: independent armed write/read pointers, optional
// auto-increment with wrap, range-checked addresses and one-cycle tx_valid/cmd_err pulses.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WORD_SIZE+1:0]   din,
   input  logic                   rx_valid,
   output logic [WORD_SIZE-1:0]   dout,
   output logic                   tx_valid,
   output logic                   cmd_err
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [WORD_SIZE:0] DEPTH_X  = (WORD_SIZE+1)'(MEM_DEPTH);
   localparam logic [AW-1:0]      LAST_PTR = AW'(MEM_DEPTH - 1);

   cmd_t                 cmd;
   logic [WORD_SIZE-1:0] payload;
   logic                 addr_ok;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   arm_state_e    wr_arm_q, wr_arm_d;
   arm_state_e    rd_arm_q, rd_arm_d;
   logic          tx_valid_q, tx_valid_d;
   logic          cmd_err_q, cmd_err_d;
   logic          mem_we, mem_re;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign cmd     = din[WORD_SIZE+1:WORD_SIZE];
   assign payload = din[WORD_SIZE-1:0];
   // Extra top bit lets MEM_DEPTH == 2**WORD_SIZE accept every payload.
   assign addr_ok = ({1'b0, payload} < DEPTH_X);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_arm_d   = wr_arm_q;
      rd_arm_d   = rd_arm_q;
      tx_valid_d = 1'b0;
      cmd_err_d  = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      if (rx_valid) begin
         case (cmd)
            CMD_WR_ADDR: begin
               if (addr_ok) begin
                  wr_ptr_d = payload[AW-1:0];
                  wr_arm_d = ARMED;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            CMD_WR_DATA: begin
               if (wr_arm_q == ARMED) begin
                  mem_we = 1'b1;
                  if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            CMD_RD_ADDR: begin
               if (addr_ok) begin
                  rd_ptr_d = payload[AW-1:0];
                  rd_arm_d = ARMED;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            default: begin
               if (rd_arm_q == ARMED) begin
                  mem_re     = 1'b1;
                  tx_valid_d = 1'b1;
                  if (AUTO_INC != 0) rd_ptr_d = ptr_inc(rd_ptr_q);
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         wr_arm_q   <= UNARMED;
         rd_arm_q   <= UNARMED;
         tx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_arm_q   <= wr_arm_d;
         rd_arm_q   <= rd_arm_d;
         tx_valid_q <= tx_valid_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   ram_array #(
      .WORD_SIZE (WORD_SIZE),
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (payload),
      .re_i    (mem_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout)
   );

   assign tx_valid = tx_valid_q;
   assign cmd_err  = cmd_err_q;

endmodule
